// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage (package fetch_pkg).
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int PC_STEP = 4;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DISCARD,
    DELIVER,
    HALT
  } state_e;

  typedef enum logic [1:0] {
    PC_HOLD,
    PC_INC,
    PC_REDIR,
    PC_PEND
  } pc_sel_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction memory req/ack, execute redirect and
// decode valid/ready. Optional misalign_o exists only with FETCH_ALIGN_CHK_EN.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic              imem_ack_i;
  logic [31:0]       imem_rdata_i;
  logic              redirect_i;
  logic [ADDR_W-1:0] redirect_pc_i;
  logic              instr_valid_o;
  logic              instr_ready_i;
  logic [31:0]       instr_o;
  logic [5:0]        instr_op_o;
  logic [ADDR_W-1:0] pc_o;
  logic [ADDR_W-1:0] pc_plus4_o;
`ifdef FETCH_ALIGN_CHK_EN
  logic              misalign_o;
`endif

  modport master (
    output imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_op_o,
           pc_o, pc_plus4_o,
`ifdef FETCH_ALIGN_CHK_EN
    output misalign_o,
`endif
    input  imem_ack_i, imem_rdata_i, redirect_i, redirect_pc_i, instr_ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_op_o,
           pc_o, pc_plus4_o,
`ifdef FETCH_ALIGN_CHK_EN
    input  misalign_o,
`endif
    output imem_ack_i, imem_rdata_i, redirect_i, redirect_pc_i, instr_ready_i
  );

endinterface

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter register (module fetch_pc_reg) with next-PC mux and the
// wrapping +4 adder.
import fetch_pkg::*;

module fetch_pc_reg #(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  pc_sel_e           sel,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic [ADDR_W-1:0] pending_pc,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4
);

  // Adder wraps naturally at 2^ADDR_W.
  assign pc_plus4 = pc + ADDR_W'(PC_STEP);

  // PC update: hold, step, take redirect, or take the parked redirect target.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      pc <= RESET_PC;
    end else begin
      case (sel)
        PC_INC:   pc <= pc_plus4;
        PC_REDIR: pc <= redirect_pc;
        PC_PEND:  pc <= pending_pc;
        default:  pc <= pc;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over req/ack, hands words to
// decode over valid/ready and squashes wrong-path fetches on redirect.
// Optional macro FETCH_ALIGN_CHK_EN adds misalign_o and the HALT state.
//
// state   | meaning
// IDLE    | one cycle after reset before the first request
// FETCH   | request outstanding at pc
// DISCARD | wrong-path request outstanding; target parked in pending_q
// DELIVER | instruction presented to decode
// HALT    | misaligned redirect seen; stopped until reset
import fetch_pkg::*;

module instr_fetch_unit #(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input logic clk_i,
  input logic rst_i,
  instr_fetch_unit_if.master bus
);

  state_e               state, state_next;
  pc_sel_e              pc_sel;
  logic [INSTR_W-1:0]   instr_q;
  logic [ADDR_W-1:0]    pending_q;
  logic [ADDR_W-1:0]    pc, pc_plus4, redir_pc;
  logic                 instr_load, pending_load, redir_halt;

`ifdef FETCH_ALIGN_CHK_EN
  logic misalign_q, misalign_set;
  assign redir_pc   = bus.redirect_pc_i;
  assign redir_halt = bus.redirect_i && (bus.redirect_pc_i[1:0] != 2'b00);
  assign bus.misalign_o = misalign_q;
`else
  // Low address bits are forced to zero: targets are always word aligned.
  assign redir_pc   = bus.redirect_pc_i & ~ADDR_W'(3);
  assign redir_halt = 1'b0;
`endif

  fetch_pc_reg #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .sel        (pc_sel),
    .redirect_pc(redir_pc),
    .pending_pc (pending_q),
    .pc         (pc),
    .pc_plus4   (pc_plus4)
  );

  assign bus.imem_req_o    = (state == FETCH) || (state == DISCARD);
  assign bus.imem_addr_o   = pc;
  assign bus.instr_valid_o = (state == DELIVER);
  assign bus.instr_o       = instr_q;
  assign bus.instr_op_o    = instr_q[OP_MSB:OP_LSB];
  assign bus.pc_o          = pc;
  assign bus.pc_plus4_o    = pc_plus4;

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_next;
  end

  // Next state, PC select and latch enables.
  always_comb begin
    state_next   = state;
    pc_sel       = PC_HOLD;
    instr_load   = 1'b0;
    pending_load = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
    misalign_set = 1'b0;
`endif
    case (state)
      IDLE: state_next = FETCH;
      FETCH: begin
        if (redir_halt) begin
          state_next = HALT;
`ifdef FETCH_ALIGN_CHK_EN
          misalign_set = 1'b1;
`endif
        end else if (bus.redirect_i) begin
          if (bus.imem_ack_i) begin
            pc_sel = PC_REDIR;
          end else begin
            pending_load = 1'b1;
            state_next   = DISCARD;
          end
        end else if (bus.imem_ack_i) begin
          instr_load = 1'b1;
          state_next = DELIVER;
        end
      end
      DISCARD: begin
        if (redir_halt) begin
          state_next = HALT;
`ifdef FETCH_ALIGN_CHK_EN
          misalign_set = 1'b1;
`endif
        end else if (bus.imem_ack_i) begin
          // A redirect arriving with the ack is newer than the parked target.
          pc_sel     = bus.redirect_i ? PC_REDIR : PC_PEND;
          state_next = FETCH;
        end else if (bus.redirect_i) begin
          pending_load = 1'b1;
        end
      end
      DELIVER: begin
        if (redir_halt) begin
          state_next = HALT;
`ifdef FETCH_ALIGN_CHK_EN
          misalign_set = 1'b1;
`endif
        end else if (bus.redirect_i) begin
          pc_sel     = PC_REDIR;
          state_next = FETCH;
        end else if (bus.instr_ready_i) begin
          pc_sel     = PC_INC;
          state_next = FETCH;
        end
      end
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  // Instruction latch, loaded on a good-path ack.
  always_ff @(posedge clk_i) begin
    if (!rst_i)          instr_q <= '0;
    else if (instr_load) instr_q <= bus.imem_rdata_i;
  end

  // Parked redirect target while a wrong-path fetch drains.
  always_ff @(posedge clk_i) begin
    if (!rst_i)            pending_q <= '0;
    else if (pending_load) pending_q <= redir_pc;
  end

`ifdef FETCH_ALIGN_CHK_EN
  // Sticky misalignment flag, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i)            misalign_q <= 1'b0;
    else if (misalign_set) misalign_q <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit.
module tb_instr_fetch_unit;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk_i = ~clk_i;

  instr_fetch_unit_if #(.ADDR_W(32)) bus ();

  instr_fetch_unit #(
    .ADDR_W  (32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.imem_ack_i    = 1'b0;
    bus.imem_rdata_i  = 32'h0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'h0;
    bus.instr_ready_i = 1'b0;
    tick();
    tick();

    // Reset values
    check("rst_req",   32'(bus.imem_req_o), 32'h0);
    check("rst_valid", 32'(bus.instr_valid_o), 32'h0);
    check("rst_instr", bus.instr_o, 32'h0);
    check("rst_pc",    bus.pc_o, 32'h0);

    // First fetch, ack one cycle after req
    rst_i = 1'b1;
    tick();
    check("f1_req",  32'(bus.imem_req_o), 32'h1);
    check("f1_addr", bus.imem_addr_o, 32'h0);
    check("f1_valid", 32'(bus.instr_valid_o), 32'h0);
    tick();
    bus.imem_ack_i = 1'b1; bus.imem_rdata_i = 32'h2001_0005;
    tick();
    bus.imem_ack_i = 1'b0;
    check("f1_dvalid", 32'(bus.instr_valid_o), 32'h1);
    check("f1_op",     32'(bus.instr_op_o), 32'h08);
    check("f1_instr",  bus.instr_o, 32'h2001_0005);
    check("f1_pc",     bus.pc_o, 32'h0);
    check("f1_pc4",    bus.pc_plus4_o, 32'h4);
    check("f1_noreq",  32'(bus.imem_req_o), 32'h0);
    bus.instr_ready_i = 1'b1;
    tick();
    bus.instr_ready_i = 1'b0;
    check("f2_addr",  bus.imem_addr_o, 32'h4);
    check("f2_valid", 32'(bus.instr_valid_o), 32'h0);

    // Ack delay 3 cycles, decode stalls 5 cycles
    for (int i = 0; i < 3; i++) begin
      check("f2_wait_req",  32'(bus.imem_req_o), 32'h1);
      check("f2_wait_addr", bus.imem_addr_o, 32'h4);
      tick();
    end
    bus.imem_ack_i = 1'b1; bus.imem_rdata_i = 32'hAC22_0010;
    tick();
    bus.imem_ack_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(bus.instr_valid_o), 32'h1);
      check("stall_instr", bus.instr_o, 32'hAC22_0010);
      check("stall_pc",    bus.pc_o, 32'h4);
      check("stall_noreq", 32'(bus.imem_req_o), 32'h0);
      tick();
    end
    bus.instr_ready_i = 1'b1;
    tick();
    bus.instr_ready_i = 1'b0;
    check("f3_addr", bus.imem_addr_o, 32'h8);
    check("f3_req",  32'(bus.imem_req_o), 32'h1);

    // Redirect in FETCH, wrong-path ack two cycles later
    bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h40;
    tick();
    bus.redirect_i = 1'b0;
    check("disc_req",   32'(bus.imem_req_o), 32'h1);
    check("disc_addr",  bus.imem_addr_o, 32'h8);
    check("disc_valid", 32'(bus.instr_valid_o), 32'h0);
    tick();
    check("disc_addr2", bus.imem_addr_o, 32'h8);
    bus.imem_ack_i = 1'b1; bus.imem_rdata_i = 32'hDEAD_BEEF;
    tick();
    bus.imem_ack_i = 1'b0;
    check("redir_valid", 32'(bus.instr_valid_o), 32'h0);
    check("redir_addr",  bus.imem_addr_o, 32'h40);
    check("redir_req",   32'(bus.imem_req_o), 32'h1);
    tick();
    bus.imem_ack_i = 1'b1; bus.imem_rdata_i = 32'h8C41_0020;
    tick();
    bus.imem_ack_i = 1'b0;
    check("redir_instr", bus.instr_o, 32'h8C41_0020);
    check("redir_pc",    bus.pc_o, 32'h40);
    check("redir_op",    32'(bus.instr_op_o), 32'h23);

    // Handshake and redirect in the same DELIVER cycle
    bus.instr_ready_i = 1'b1; bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h100;
    tick();
    bus.instr_ready_i = 1'b0; bus.redirect_i = 1'b0;
    check("hsr_valid", 32'(bus.instr_valid_o), 32'h0);
    check("hsr_addr",  bus.imem_addr_o, 32'h100);

    // Reset mid-DISCARD with a late ack
    bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h200;
    tick();
    bus.redirect_i = 1'b0;
    check("mrst_disc_addr", bus.imem_addr_o, 32'h100);
    tick();
    rst_i = 1'b0;
    tick();
    check("mrst_req",   32'(bus.imem_req_o), 32'h0);
    check("mrst_valid", 32'(bus.instr_valid_o), 32'h0);
    check("mrst_instr", bus.instr_o, 32'h0);
    check("mrst_pc",    bus.pc_o, 32'h0);
    rst_i = 1'b1;
    bus.imem_ack_i = 1'b1; bus.imem_rdata_i = 32'hBAD0_BAD0;
    tick();
    bus.imem_ack_i = 1'b0;
    check("prst_req",   32'(bus.imem_req_o), 32'h1);
    check("prst_addr",  bus.imem_addr_o, 32'h0);
    check("prst_valid", 32'(bus.instr_valid_o), 32'h0);
    tick();
    bus.imem_ack_i = 1'b1; bus.imem_rdata_i = 32'h1234_5678;
    tick();
    bus.imem_ack_i = 1'b0;
    check("prst_instr", bus.instr_o, 32'h1234_5678);
    check("prst_pc",    bus.pc_o, 32'h0);

    // PC wrap at the top of the address space
    bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    bus.redirect_i = 1'b0;
    check("wrap_addr", bus.imem_addr_o, 32'hFFFF_FFFC);
    tick();
    bus.imem_ack_i = 1'b1; bus.imem_rdata_i = 32'h0000_0001;
    tick();
    bus.imem_ack_i = 1'b0;
    check("wrap_pc",  bus.pc_o, 32'hFFFF_FFFC);
    check("wrap_pc4", bus.pc_plus4_o, 32'h0);
    bus.instr_ready_i = 1'b1;
    tick();
    bus.instr_ready_i = 1'b0;
    check("wrap_next", bus.imem_addr_o, 32'h0);

    // Two redirects while discarding: the newest wins
    bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h300;
    tick();
    bus.redirect_pc_i = 32'h304;
    tick();
    bus.redirect_i = 1'b0;
    check("newest_disc_addr", bus.imem_addr_o, 32'h0);
    bus.imem_ack_i = 1'b1;
    tick();
    bus.imem_ack_i = 1'b0;
    check("newest_addr", bus.imem_addr_o, 32'h304);
    check("newest_req",  32'(bus.imem_req_o), 32'h1);

    // Misaligned redirect from DELIVER
    tick();
    bus.imem_ack_i = 1'b1; bus.imem_rdata_i = 32'h0000_0001;
    tick();
    bus.imem_ack_i = 1'b0;
    check("mis_pc", bus.pc_o, 32'h304);
    bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h42;
    tick();
    bus.redirect_i = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
    check("mis_flag",  32'(bus.misalign_o), 32'h1);
    check("mis_req",   32'(bus.imem_req_o), 32'h0);
    check("mis_valid", 32'(bus.instr_valid_o), 32'h0);
    bus.imem_ack_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("halt_req",   32'(bus.imem_req_o), 32'h0);
      check("halt_flag",  32'(bus.misalign_o), 32'h1);
      check("halt_valid", 32'(bus.instr_valid_o), 32'h0);
    end
    bus.imem_ack_i = 1'b0;
`else
    check("align_addr", bus.imem_addr_o, 32'h40);
    check("align_req",  32'(bus.imem_req_o), 32'h1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
